// File: rtl/cam_capture_rgb565_if.sv
// Write-port bus from the camera capture block into the CNN input buffer.
interface cam_capture_rgb565_if #(
  parameter int ADDR_W = 17
);
  logic              oWrEn;
  logic [ADDR_W-1:0] oWrAddr;
  logic [15:0]       oWrData;

  modport master (output oWrEn, output oWrAddr, output oWrData);
  modport slave  (input  oWrEn, input  oWrAddr, input  oWrData);
endinterface

// File: rtl/cam_capture_rgb565.sv
// DVP camera capture: pairs bytes into RGB565, crops to DST_W x DST_H, writes raster-addressed words.
// Define CAM_BYTE_SWAP_EN for sensors that send the low byte of each pixel first.
module cam_capture_rgb565 #(
  parameter int SRC_W  = 640,
  parameter int SRC_H  = 480,
  parameter int DST_W  = 480,
  parameter int DST_H  = 272,
  parameter int X_OFF  = 80,
  parameter int Y_OFF  = 104,
  parameter int ADDR_W = 17
) (
  input  logic                        iClk,
  input  logic                        iRsn,
  input  logic                        iCapEn,
  input  logic                        iCamPclk,
  input  logic                        iCamVsync,
  input  logic                        iCamHref,
  input  logic [7:0]                  iCamData,
  cam_capture_rgb565_if.master        wr_bus,
  output logic                        oFrameDone,
  output logic                        oErr
);

  localparam int CW    = $clog2(SRC_W + 2) + 1;
  localparam int RW    = $clog2(SRC_H + 2) + 1;
  localparam int TOTAL = DST_W * DST_H;

  localparam logic [CW-1:0]     C_LO    = CW'(X_OFF);
  localparam logic [CW-1:0]     C_HI    = CW'(X_OFF + DST_W);
  localparam logic [CW-1:0]     C_SRC   = CW'(SRC_W);
  localparam logic [CW-1:0]     C_MAX   = {CW{1'b1}};
  localparam logic [RW-1:0]     R_LO    = RW'(Y_OFF);
  localparam logic [RW-1:0]     R_HI    = RW'(Y_OFF + DST_H);
  localparam logic [RW-1:0]     R_SRC   = RW'(SRC_H);
  localparam logic [RW-1:0]     R_MAX   = {RW{1'b1}};
  localparam logic [ADDR_W:0]   A_TOTAL = (ADDR_W + 1)'(TOTAL);
  localparam logic [ADDR_W:0]   A_ONE   = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    ACTIVE   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [2:0]        r_pclk_s;
  logic [2:0]        r_vs_s;
  logic [1:0]        r_href_s;
  logic [7:0]        r_data_s1;
  logic [7:0]        r_data_s2;
  logic              r_href_prev;
  logic              r_phase;
  logic [7:0]        r_hi;
  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic [ADDR_W:0]   r_addr;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [15:0]       r_wr_data;
  logic              r_done;
  logic              r_err;

  logic              w_pclk_rise;
  logic              w_vs_rise;
  logic              w_vs_fall;
  logic              w_href;
  logic              w_sof;
  logic              w_eof;
  logic              w_cap;
  logic              w_in_crop;
  logic              w_full;
  logic [15:0]       w_word;

  assign w_pclk_rise = r_pclk_s[1] & ~r_pclk_s[2];
  assign w_vs_rise   = r_vs_s[1] & ~r_vs_s[2];
  assign w_vs_fall   = ~r_vs_s[1] & r_vs_s[2];
  assign w_href      = r_href_s[1];
  // VSYNC rise wins over any byte event in the same cycle, so a coincident write is dropped
  assign w_cap       = (r_state == ACTIVE) && w_pclk_rise && !w_vs_rise;
  assign w_in_crop   = (r_col >= C_LO) && (r_col < C_HI) && (r_row >= R_LO) && (r_row < R_HI);
  assign w_full      = (r_addr == A_TOTAL);
`ifdef CAM_BYTE_SWAP_EN
  assign w_word      = {r_data_s2, r_hi};
`else
  assign w_word      = {r_hi, r_data_s2};
`endif

  // Two-flop synchronisers, with one extra stage on PCLK and VSYNC for edge detection
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      r_pclk_s  <= 3'b000;
      r_vs_s    <= 3'b000;
      r_href_s  <= 2'b00;
      r_data_s1 <= 8'h00;
      r_data_s2 <= 8'h00;
    end else begin
      r_pclk_s  <= {r_pclk_s[1:0], iCamPclk};
      r_vs_s    <= {r_vs_s[1:0], iCamVsync};
      r_href_s  <= {r_href_s[0], iCamHref};
      r_data_s1 <= iCamData;
      r_data_s2 <= r_data_s1;
    end
  end

  // Frame state register
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Frame sequencing: start of frame on VSYNC fall, end of frame on VSYNC rise
  always_comb begin
    w_state_nxt = r_state;
    w_sof       = 1'b0;
    w_eof       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_vs_rise) w_state_nxt = WAIT_SOF;
        else           w_state_nxt = IDLE;
      end
      WAIT_SOF: begin
        if (w_vs_fall && iCapEn) begin
          w_state_nxt = ACTIVE;
          w_sof       = 1'b1;
        end else begin
          w_state_nxt = WAIT_SOF;
        end
      end
      ACTIVE: begin
        if (w_vs_rise) begin
          w_state_nxt = WAIT_SOF;
          w_eof       = 1'b1;
        end else begin
          w_state_nxt = ACTIVE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Byte pairing, line accounting, crop and buffer writes
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      r_href_prev <= 1'b0;
      r_phase     <= 1'b0;
      r_hi        <= 8'h00;
      r_col       <= {CW{1'b0}};
      r_row       <= {RW{1'b0}};
      r_addr      <= {(ADDR_W + 1){1'b0}};
      r_wr_en     <= 1'b0;
      r_wr_addr   <= {ADDR_W{1'b0}};
      r_wr_data   <= 16'h0000;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= w_eof;
      if (w_pclk_rise) r_href_prev <= w_href;
      if (w_sof) begin
        r_phase <= 1'b0;
        r_col   <= {CW{1'b0}};
        r_row   <= {RW{1'b0}};
        r_addr  <= {(ADDR_W + 1){1'b0}};
        r_err   <= 1'b0;
      end else if (w_eof) begin
        r_phase <= 1'b0;
        if (r_addr < A_TOTAL) r_err <= 1'b1;
      end else if (w_cap) begin
        if (w_href) begin
          if (r_row >= R_SRC) r_err <= 1'b1;
          if (!r_phase) begin
            r_hi    <= r_data_s2;
            r_phase <= 1'b1;
          end else begin
            r_phase <= 1'b0;
            if (r_col != C_MAX) r_col <= r_col + CW'(1);
            if (w_in_crop) begin
              if (w_full) begin
                r_err <= 1'b1;
              end else begin
                r_wr_en   <= 1'b1;
                r_wr_data <= w_word;
                r_wr_addr <= r_addr[ADDR_W-1:0];
                r_addr    <= r_addr + A_ONE;
              end
            end
          end
        end else begin
          r_phase <= 1'b0;
          if (r_href_prev) begin
            r_col <= {CW{1'b0}};
            if (r_row != R_MAX) r_row <= r_row + RW'(1);
            if (r_phase || (r_col != C_SRC)) r_err <= 1'b1;
          end
        end
      end
    end
  end

  assign wr_bus.oWrEn   = r_wr_en;
  assign wr_bus.oWrAddr = r_wr_addr;
  assign wr_bus.oWrData = r_wr_data;
  assign oFrameDone     = r_done;
  assign oErr           = r_err;

endmodule
